// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM data-memory stage SRAM controller.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_word_cache.sv
// One-entry last-word cache: valid/tag/data register with a combinational hit compare.
module sram_word_cache #(
  parameter int unsigned TAG_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] lookup_tag_i,
  input  logic             upd_en_i,
  input  logic [TAG_W-1:0] upd_tag_i,
  input  logic [31:0]      upd_data_i,
  output logic             hit_o,
  output logic [31:0]      hit_data_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (upd_en_i) begin
      valid_q <= 1'b1;
      tag_q   <= upd_tag_i;
      data_q  <= upd_data_i;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_tag_i);
  assign hit_data_o = data_q;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: each 32-bit access becomes two wait-stated 16-bit SRAM accesses.
// Optional one-entry read cache enabled by defining SRAM_LAST_WORD_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for rd_en/wr_en; ready = no request
// LOW   | low half-word on the bus for WAIT_CYCLES+1 cycles
// HIGH  | high half-word on the bus for WAIT_CYCLES+1 cycles
// DONE  | ready=1 for one cycle, pipeline advances
module sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int unsigned IDX_W  = SRAM_AW - 1;
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES);

  mem_state_e         state_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic               is_wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [15:0]        rd_lo_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic               ce_n_q;
  logic               oe_n_q;
  logic               we_n_q;
  logic               dq_oe_q;

  logic               req;
  logic [IDX_W-1:0]   idx_w;
  logic               wait_done;
  logic               cache_hit;
  logic [31:0]        cache_data;

  assign req       = rd_en | wr_en;
  // Modulo-2^32 offset, then truncation: out-of-range addresses wrap silently.
  assign idx_w     = IDX_W'((address - BASE_ADDR) >> 2);
  assign wait_done = (wcnt_q == WCNT_LAST);

`ifdef SRAM_LAST_WORD_CACHE_EN
  sram_word_cache #(
    .TAG_W (IDX_W)
  ) u_cache (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (idx_w),
    .upd_en_i     (state_q == ST_DONE),
    .upd_tag_i    (idx_q),
    .upd_data_i   (is_wr_q ? wdata_q : read_data_q),
    .hit_o        (cache_hit),
    .hit_data_o   (cache_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b1 ^ 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wcnt_q <= '0;
          if (req) begin
            // Request is latched so a mid-access protocol violation cannot corrupt it.
            is_wr_q <= wr_en;
            idx_q   <= idx_w;
            wdata_q <= write_data;
            if (!wr_en && cache_hit) begin
              read_data_q <= cache_data;
              state_q     <= ST_DONE;
            end else begin
              state_q     <= ST_LOW;
              sram_addr_q <= {idx_w, HALF_LO};
              ce_n_q      <= 1'b0;
              oe_n_q      <= wr_en;
              we_n_q      <= ~wr_en;
              dq_oe_q     <= wr_en;
            end
          end
        end
        ST_LOW: begin
          if (wait_done) begin
            wcnt_q      <= '0;
            state_q     <= ST_HIGH;
            sram_addr_q <= {idx_q, HALF_HI};
            if (!is_wr_q) rd_lo_q <= sram_dq_i;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (wait_done) begin
            wcnt_q  <= '0;
            state_q <= ST_DONE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            // read_data only changes here so it holds its value during the access.
            if (!is_wr_q) read_data_q <= {sram_dq_i, rd_lo_q};
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready      = (state_q == ST_IDLE) ? ~req : (state_q == ST_DONE);
  assign read_data  = read_data_q;
  assign sram_addr  = sram_addr_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_dq_o  = !dq_oe_q ? 16'h0000 :
                      (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a behavioural SRAM; W=2, BASE_ADDR=1024.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int errors = 0;
  int checks = 0;

`ifdef SRAM_LAST_WORD_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 7;
`endif

  always #5 clk = ~clk;

  sram_mem_ctrl #(
    .BASE_ADDR   (32'd1024),
    .SRAM_AW     (18),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  logic [15:0] mem [0:262143];

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_o;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [17:0] a1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    logic [17:0] a1;
    logic        ce_seen;
    logic        done;
    drive_req(v.rd, v.wr, v.addr, v.wdata);
    n = 0; done = 1'b0; ce_seen = 1'b0; a1 = '0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (!sram_ce_n) ce_seen = 1'b1;
      if (n == 1) a1 = sram_addr;
      if (ready) done = 1'b1;
      else n++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
    chk($sformatf("v%0d_sram_used", idx), {31'h0, ce_seen}, {31'h0, v.lat == 7});
    if (v.chk_rd) chk($sformatf("v%0d_read_data", idx), read_data, v.rdata);
    if (v.lat == 7) chk($sformatf("v%0d_addr_c1", idx), {14'h0, a1}, {14'h0, v.a1});
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    vec_t rv;
    logic act;

    vecs[0] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 7,       1'b0, 32'h0,        18'd4};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        HIT_LAT, 1'b1, 32'h12345678, 18'd4};
    vecs[2] = '{1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 7,       1'b0, 32'h0,        18'h3FFFE};
    vecs[3] = '{1'b1, 1'b0, 32'd1020, 32'h0,        HIT_LAT, 1'b1, 32'h0BADF00D, 18'h3FFFE};
    vecs[4] = '{1'b1, 1'b0, 32'd1031, 32'h0,        7,       1'b1, 32'hDEADBEEF, 18'd2};
    vecs[5] = '{1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 7,       1'b0, 32'h0,        18'd6};
    vecs[6] = '{1'b1, 1'b0, 32'd1036, 32'h0,        HIT_LAT, 1'b1, 32'hCAFEF00D, 18'd6};
    vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h0,        7,       1'b1, 32'h12345678, 18'd4};

    // Idle after reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'h0, ready}, 32'h1);
    chk("idle_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("idle_oe_n", {31'h0, sram_oe_n}, 32'h1);
    chk("idle_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("idle_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("idle_read_data", read_data, 32'h0);
    chk("idle_sram_addr", {14'h0, sram_addr}, 32'h0);

    // Write 0xDEADBEEF to 1028, cycle by cycle
    drive_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      act = (k >= 1 && k <= 6);
      chk($sformatf("wr_c%0d_ready", k), {31'h0, ready}, {31'h0, k == 7});
      chk($sformatf("wr_c%0d_we_n", k), {31'h0, sram_we_n}, {31'h0, !act});
      chk($sformatf("wr_c%0d_ce_n", k), {31'h0, sram_ce_n}, {31'h0, !act});
      if (act) begin
        chk($sformatf("wr_c%0d_addr", k), {14'h0, sram_addr}, (k <= 3) ? 32'd2 : 32'd3);
        chk($sformatf("wr_c%0d_dq_o", k), {16'h0, sram_dq_o}, (k <= 3) ? 32'hBEEF : 32'hDEAD);
        chk($sformatf("wr_c%0d_dq_oe", k), {31'h0, sram_dq_oe}, 32'h1);
      end
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Read 1028 back cycle by cycle; cache holds 1032 so this always misses
    drive_req(1'b1, 1'b0, 32'd1028, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      act = (k >= 1 && k <= 6);
      chk($sformatf("rd_c%0d_ready", k), {31'h0, ready}, {31'h0, k == 7});
      chk($sformatf("rd_c%0d_oe_n", k), {31'h0, sram_oe_n}, {31'h0, !act});
      chk($sformatf("rd_c%0d_we_n", k), {31'h0, sram_we_n}, 32'h1);
      chk($sformatf("rd_c%0d_read_data", k), read_data, (k == 7) ? 32'hDEADBEEF : 32'h12345678);
    end
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset pulsed in cycle 5 of a write
    drive_req(1'b0, 1'b1, 32'd1044, 32'h55AA33CC);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("rstw_c4_we_n", {31'h0, sram_we_n}, 32'h0);
    chk("rstw_c4_ready", {31'h0, ready}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstw_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rstw_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("rstw_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("rstw_read_data", read_data, 32'h0);
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_after_ready", {31'h0, ready}, 32'h1);
    chk("rstw_after_ce_n", {31'h0, sram_ce_n}, 32'h1);
    rv = '{1'b1, 1'b0, 32'd1028, 32'h0, 7, 1'b1, 32'hDEADBEEF, 18'd2};
    run_vec(rv, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage data-memory controller for the ARM pipeline. It consumes the EXE-stage results: `alu_res` as the address, `val_Rm` as the store data, and `mem_r_en`/`mem_w_en` from the EXE/MEM register. It serves each 32-bit word access as two 16-bit half-word accesses on an external wait-stated SRAM. It returns `ready`, and the hazard/freeze logic uses it to stall every pipeline register while an access is in flight.

## Interface
- `BASE_ADDR`, 1024: data-memory base; the word index is `(address - BASE_ADDR) >> 2`.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 2: extra cycles each half access is held (W); each half lasts W+1 cycles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_en` in 1: load request (`mem_r_en`). Held stable while `ready`=0.
- `wr_en` in 1: store request (`mem_w_en`). Held stable while `ready`=0.
- `address` in 32: byte address (`alu_res`). Bits [1:0] are ignored.
- `write_data` in 32: store data (`val_Rm`).
- `read_data` out 32: load result. Valid in the cycle `ready`=1 ends a read; holds its value otherwise.
- `ready` out 1: 0 = freeze the pipeline.
- `sram_addr` out SRAM_AW: half-word address = {word_idx[SRAM_AW-2:0], half}.
- `sram_dq_o` out 16: write half-word.
- `sram_dq_oe` out 1: drive enable for the data bus.
- `sram_dq_i` in 16: read half-word.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: active-low SRAM strobes.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter `wcnt` counts 0..W.
- IDLE:
  - If `wr_en` or `rd_en` is set, go to LOW with `wcnt`=0.
  - `ready` = ~(`rd_en` | `wr_en`), a combinational function of the request in IDLE only.
- LOW: `sram_addr` = {idx,0}; the low half-word is `data[15:0]`. Stay until `wcnt`=W, then go to HIGH with `wcnt` cleared.
- HIGH: `sram_addr` = {idx,1}; the high half-word is `data[31:16]`. At `wcnt`=W, go to DONE.
- DONE: `ready`=1 for exactly one cycle, then return to IDLE. The pipeline advances on this edge, so any request seen in the next IDLE belongs to a new instruction.
- Strobes in LOW/HIGH:
  - `sram_ce_n`=0 throughout.
  - Write: `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_o` = the corresponding half of `write_data`.
  - Read: `sram_oe_n`=0. `sram_dq_i` is captured into the matching half of `read_data` on the edge leaving the state (`wcnt`=W).
- All strobes are inactive in IDLE and DONE. SRAM outputs are registered or decoded purely from state, so they are glitch-free.
- `rd_en` and `wr_en` together: treated as a write.
- Address arithmetic: 32-bit subtraction modulo 2^32, then truncation to SRAM_AW-1 bits. There is no range check; out-of-range addresses wrap.

## Timing
- Reset values: state=IDLE, `wcnt`=0, `read_data`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, all `*_n`=1.
- `ready` reads 1 while idle with no request.
- The request is first seen in cycle 0 (IDLE, `ready`=0):
  - LOW occupies cycles 1..W+1.
  - HIGH occupies cycles W+2..2W+2.
  - DONE is cycle 2W+3 (`ready`=1).
  - The freeze lasts 2W+3 cycles.
- `rst` asserted mid-access: strobes deassert immediately and the FSM returns to IDLE. A write interrupted in HIGH leaves the low half committed; this is accepted.
- `rd_en`/`wr_en` dropping while `ready`=0 is a protocol violation. The access completes regardless.

## Configuration
- `SRAM_LAST_WORD_CACHE_EN` defined:
  - A one-entry cache holds the last word written or read (valid bit, word_idx, data).
  - A read whose word_idx matches a valid entry skips the SRAM and goes IDLE→DONE. `ready` is 0 in cycle 0 and 1 in cycle 1, with no strobe activity.
  - Writes always go to the SRAM and update the entry at DONE.
  - Reset clears the valid bit.
- Undefined: there is no cache, and every access takes the full 2W+4 cycles.

## Structure
- Shared package `arm_mem_pkg`: the FSM state enum, the `BASE_ADDR` default, and the half-word select constants.
- Sub-module `sram_word_cache` (valid/tag/data register plus hit compare) is instantiated only under `SRAM_LAST_WORD_CACHE_EN`. The wait counter stays inline.

## Test plan
All scenarios use W=2 and BASE_ADDR=1024.
- **Idle:** reset, then no request → `ready`=1; all `*_n`=1; `read_data`=0.
- **Write:** write 0xDEADBEEF to 1028 → `sram_addr`=2 with `dq_o`=0xBEEF and `we_n`=0 in cycles 1–3. Then `sram_addr`=3 with 0xDEAD in cycles 4–6. `ready`=0 in cycles 0–6 and 1 in cycle 7.
- **Read:** read 1028 from a behavioural SRAM holding the above → `oe_n`=0 in cycles 1–6; `read_data`=0xDEADBEEF with `ready`=1 in cycle 7.
- **Both enables:** `rd_en`=`wr_en`=1 to 1032 with 0x12345678 → a write occurs; a later read returns 0x12345678.
- **Reset mid-write:** `rst` pulsed in cycle 5 of a write → `we_n`=1 and `ce_n`=1 in the same cycle; after release `ready`=1 and the state is IDLE.
- **Cache (`SRAM_LAST_WORD_CACHE_EN`):** write 0xCAFEF00D to 1036, then read 1036 → `ready`=1 in cycle 1 and `read_data`=0xCAFEF00D with no `ce_n` activity. A read of 1040 takes the full 8 cycles.
